// File: rtl/pattern_shift_timer_pkg.sv
// Shared state encodings and width helper for the serial-command-triggered timer.
package pattern_shift_timer_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_detector.sv
// Serial pattern matcher: history shift register plus a fill counter so a match
// needs at least PATTERN_LEN bits received since the last clear.
module pattern_detector
  import pattern_shift_timer_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic data,
  output logic match
);

  localparam int FW = $clog2(PATTERN_LEN + 1);

  logic [PATTERN_LEN-2:0] hist_reg;
  logic [FW-1:0]          fill_reg;
  logic [PATTERN_LEN-1:0] window;

  // The current bit completes the window, so a match is seen on the edge that samples it.
  assign window = {hist_reg, data};
  assign match  = en && (window == PATTERN) && (fill_reg >= FW'(PATTERN_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (en) begin
      hist_reg <= window[PATTERN_LEN-2:0];
      if (fill_reg != FW'(PATTERN_LEN))
        fill_reg <= fill_reg + FW'(1);
    end
  end

endmodule

// File: rtl/pattern_shift_timer.sv
// Pattern-triggered timer: detect PATTERN, shift in a delay, count
// (delay+1)*CNT_CYCLES cycles, then hold done until ack.
module pattern_shift_timer
  import pattern_shift_timer_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                     SHIFT_BITS  = 4,
  parameter int                     CNT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data,
  input  logic                  ack,
  output logic                  start_shifting,
  output logic                  shift_ena,
  output logic                  counting,
  output logic                  done,
  output logic [SHIFT_BITS-1:0] count
);

  localparam int CW = width_of(CNT_CYCLES);
  localparam int SW = width_of(SHIFT_BITS);
  localparam logic [CW-1:0] CYC_RELOAD = CW'(CNT_CYCLES - 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_BITS - 1);

  logic [1:0]            state_reg, state_next;
  logic [SW-1:0]         shift_cnt_reg;
  logic [SHIFT_BITS-1:0] delay_reg, delay_shifted;
  logic [CW-1:0]         cyc_reg;
  logic                  match;
  logic                  det_en, det_clear;

  assign det_en    = (state_reg == ST_SEARCH);
  assign det_clear = (state_reg == ST_DONE) && ack;

  pattern_detector #(
    .PATTERN_LEN(PATTERN_LEN),
    .PATTERN    (PATTERN)
  ) u_detector (
    .clk  (clk),
    .reset(reset),
    .clear(det_clear),
    .en   (det_en),
    .data (data),
    .match(match)
  );

  generate
    if (SHIFT_BITS == 1) begin : g_shift_one
      assign delay_shifted = data;
    end else begin : g_shift_many
      assign delay_shifted = {delay_reg[SHIFT_BITS-2:0], data};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SEARCH: if (match) state_next = ST_SHIFT;
      ST_SHIFT:  if (shift_cnt_reg == SHIFT_LAST) state_next = ST_COUNT;
      ST_COUNT:  if (cyc_reg == '0 && delay_reg == '0) state_next = ST_DONE;
      ST_DONE:   if (ack) state_next = ST_SEARCH;
      default:   state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_SEARCH;
      shift_cnt_reg <= '0;
      delay_reg     <= '0;
      cyc_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_SEARCH: if (match) shift_cnt_reg <= '0;
        ST_SHIFT: begin
          delay_reg     <= delay_shifted;
          shift_cnt_reg <= shift_cnt_reg + SW'(1);
          if (shift_cnt_reg == SHIFT_LAST) cyc_reg <= CYC_RELOAD;
        end
        ST_COUNT: begin
          // Each delay unit spans CNT_CYCLES edges; delay==0 still runs one full unit.
          if (cyc_reg != '0) begin
            cyc_reg <= cyc_reg - CW'(1);
          end else if (delay_reg != '0) begin
            delay_reg <= delay_reg - SHIFT_BITS'(1);
            cyc_reg   <= CYC_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_ena      = (state_reg == ST_SHIFT);
  assign start_shifting = shift_ena && (shift_cnt_reg == '0);
  assign counting       = (state_reg == ST_COUNT);
  assign done           = (state_reg == ST_DONE);
  assign count          = counting ? delay_reg : '0;

endmodule
